// File: rtl/lif_timestep_scheduler_if.sv
// Event stream between the AXI-side event router and the timestep scheduler.
//   ev_valid      : router offers an event
//   ev_ready      : scheduler's event buffer can take it (buffer not full)
//   ev_neuron_id  : target neuron index
//   ev_weight     : synaptic weight
//   ev_excitatory : 1 excitatory, 0 inhibitory
// master = event router, slave = scheduler.
interface lif_timestep_scheduler_if #(
  parameter int NEURON_ID_WIDTH = 4,
  parameter int WEIGHT_WIDTH    = 8
);
  logic                       ev_valid;
  logic                       ev_ready;
  logic [NEURON_ID_WIDTH-1:0] ev_neuron_id;
  logic [WEIGHT_WIDTH-1:0]    ev_weight;
  logic                       ev_excitatory;

  modport master (
    output ev_valid,
    output ev_neuron_id,
    output ev_weight,
    output ev_excitatory,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_neuron_id,
    input  ev_weight,
    input  ev_excitatory,
    output ev_ready
  );
endinterface

// File: rtl/lif_timestep_scheduler.sv
// Buffers synaptic events and sequences a bank of parallel LIF neurons through
// one timestep per ts_start pulse: a delivery phase (one buffered event per
// cycle, one-hot enable/syn_valid with a broadcast weight) followed by a single
// leak cycle that enables every neuron with syn_valid low.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   ts_start       : single-cycle request to run one timestep (ignored when busy)
//   ev             : event stream slave (valid/ready, id, weight, polarity)
//   neu_enable     : per-neuron enable (registered)
//   neu_syn_valid  : per-neuron synaptic-input strobe (registered)
//   neu_weight     : broadcast weight (registered)
//   neu_excitatory : broadcast polarity (registered)
//   busy           : high while a timestep is in progress
//   ts_done        : one-cycle pulse coinciding with the leak strobe
//   ts_count       : completed timesteps, wrapping
//   drop_count     : events discarded for an out-of-range id, saturating
//   fifo_level     : event buffer occupancy, 0..FIFO_DEPTH
module lif_timestep_scheduler #(
  parameter int NUM_NEURONS     = 16,
  parameter int NEURON_ID_WIDTH = 4,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ts_start,
  lif_timestep_scheduler_if.slave    ev,
  output logic [NUM_NEURONS-1:0]     neu_enable,
  output logic [NUM_NEURONS-1:0]     neu_syn_valid,
  output logic [WEIGHT_WIDTH-1:0]    neu_weight,
  output logic                       neu_excitatory,
  output logic                       busy,
  output logic                       ts_done,
  output logic [CNT_WIDTH-1:0]       ts_count,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);

  localparam int ENTRY_W = NEURON_ID_WIDTH + WEIGHT_WIDTH + 1;
  localparam logic [FIFO_ADDR_WIDTH:0]   FULL_LEVEL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0]   LEVEL_ONE  = (FIFO_ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE    = FIFO_ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]       CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [NUM_NEURONS-1:0]     NEU_LSB    = NUM_NEURONS'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, LEAK, DONE} state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0]         mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   level;
  logic [FIFO_ADDR_WIDTH:0]   pending;
  logic                       push, pop;
  logic [NEURON_ID_WIDTH-1:0] pop_id;
  logic [WEIGHT_WIDTH-1:0]    pop_weight;
  logic                       pop_exc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign ev.ev_ready = (level != FULL_LEVEL);
  assign push        = ev.ev_valid && ev.ev_ready;
  // DRAIN is only entered with pending > 0 and pending never exceeds the
  // occupancy, so popping in DRAIN never underflows the buffer.
  assign pop         = (state == DRAIN);
  assign {pop_exc, pop_weight, pop_id} = mem[rd_ptr];

  assign busy       = (state != IDLE);
  assign fifo_level = level;

  // Event buffer storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev.ev_excitatory, ev.ev_weight, ev.ev_neuron_id};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ts_start) state_next = (level != '0) ? DRAIN : LEAK;
      DRAIN:   if (pending == LEVEL_ONE) state_next = LEAK;
      LEAK:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer bookkeeping, pending snapshot, and the registered neuron strobes
  // for the cycle after each pop / leak decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      pending        <= '0;
      neu_enable     <= '0;
      neu_syn_valid  <= '0;
      neu_weight     <= '0;
      neu_excitatory <= 1'b0;
      ts_done        <= 1'b0;
      ts_count       <= '0;
      drop_count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: ;
      endcase

      // The snapshot uses the registered level, so a push in the ts_start
      // cycle is left for the next timestep.
      if ((state == IDLE) && ts_start) pending <= level;
      else if (pop)                    pending <= pending - LEVEL_ONE;

      neu_enable     <= '0;
      neu_syn_valid  <= '0;
      neu_weight     <= '0;
      neu_excitatory <= 1'b0;
      ts_done        <= 1'b0;

      if (pop) begin
        if (int'(pop_id) < NUM_NEURONS) begin
          neu_enable     <= NEU_LSB << pop_id;
          neu_syn_valid  <= NEU_LSB << pop_id;
          neu_weight     <= pop_weight;
          neu_excitatory <= pop_exc;
        end else begin
          drop_count <= sat_inc(drop_count);
        end
      end

      // Leak strobe, ts_done and the new ts_count all become visible together
      // in the DONE cycle.
      if (state == LEAK) begin
        neu_enable <= '1;
        ts_done    <= 1'b1;
        ts_count   <= ts_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
`timescale 1ns/1ps
module tb_lif_timestep_scheduler;
  localparam int NN    = 16;
  localparam int NN12  = 12;
  localparam int IDW   = 4;
  localparam int WW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WW-1:0]  w;
    logic           exc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ts16, ts12;

  lif_timestep_scheduler_if #(.NEURON_ID_WIDTH(IDW), .WEIGHT_WIDTH(WW)) ev16();
  lif_timestep_scheduler_if #(.NEURON_ID_WIDTH(IDW), .WEIGHT_WIDTH(WW)) ev12();

  logic [NN-1:0]   en16, sv16;
  logic [WW-1:0]   w16;
  logic            x16, busy16, done16;
  logic [CW-1:0]   tsc16, drop16;
  logic [4:0]      lvl16;

  logic [NN12-1:0] en12, sv12;
  logic [WW-1:0]   w12;
  logic            x12, busy12, done12;
  logic [CW-1:0]   tsc12, drop12;
  logic [4:0]      lvl12;

  lif_timestep_scheduler dut16 (
    .clk(clk), .rst_n(rst_n), .ts_start(ts16), .ev(ev16.slave),
    .neu_enable(en16), .neu_syn_valid(sv16), .neu_weight(w16), .neu_excitatory(x16),
    .busy(busy16), .ts_done(done16), .ts_count(tsc16), .drop_count(drop16), .fifo_level(lvl16)
  );

  lif_timestep_scheduler #(.NUM_NEURONS(NN12)) dut12 (
    .clk(clk), .rst_n(rst_n), .ts_start(ts12), .ev(ev12.slave),
    .neu_enable(en12), .neu_syn_valid(sv12), .neu_weight(w12), .neu_excitatory(x12),
    .busy(busy12), .ts_done(done12), .ts_count(tsc12), .drop_count(drop12), .fifo_level(lvl12)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model for dut16: buffered events in arrival order, plus the
  // position (m_k cycles after ts_start) inside the current timestep.
  ev_t         q[$];
  ev_t         deliv[$];
  bit          m_active;
  int          m_k, m_e;
  logic [15:0] m_ts, m_drop;

  task automatic mdl_reset();
    q.delete();
    deliv.delete();
    m_active = 1'b0;
    m_k = 0;
    m_e = 0;
    m_ts = '0;
    m_drop = '0;
  endtask

  task automatic mdl_tick();
    ev_t  ne;
    logic acc;
    acc    = ev16.ev_valid && (q.size() < DEPTH);
    ne.id  = ev16.ev_neuron_id;
    ne.w   = ev16.ev_weight;
    ne.exc = ev16.ev_excitatory;
    if (m_active) begin
      if (m_k <= m_e) void'(q.pop_front());
      m_k++;
      if (m_k > m_e + 2) m_active = 1'b0;
      else if (m_k == m_e + 2) m_ts++;
      else if (m_k >= 2) begin
        if (int'(deliv[m_k-2].id) >= NN && m_drop != 16'hFFFF) m_drop++;
      end
    end else if (ts16) begin
      m_e = q.size();
      deliv = q;
      m_active = 1'b1;
      m_k = 1;
    end
    if (acc) q.push_back(ne);
  endtask

  function automatic logic [80:0] exp_vec();
    logic [15:0] en, sv;
    logic [7:0]  w;
    logic        x, b, d, rdy;
    logic [4:0]  lv;
    ev_t         e;
    en = '0; sv = '0; w = '0; x = 1'b0; d = 1'b0;
    b = m_active;
    rdy = (q.size() < DEPTH);
    lv = 5'(q.size());
    if (m_active && m_k >= 2 && m_k <= m_e + 1) begin
      e = deliv[m_k-2];
      if (int'(e.id) < NN) begin
        en = 16'd1 << e.id;
        sv = en;
        w  = e.w;
        x  = e.exc;
      end
    end
    if (m_active && m_k == m_e + 2) begin
      en = '1;
      d  = 1'b1;
    end
    return {rdy, en, sv, w, x, b, d, m_ts, m_drop, lv};
  endfunction

  function automatic logic [80:0] dut_vec();
    return {ev16.ev_ready, en16, sv16, w16, x16, busy16, done16, tsc16, drop16, lvl16};
  endfunction

  task automatic drive16(input logic v, input logic [IDW-1:0] id, input logic [WW-1:0] w, input logic x);
    ev16.ev_valid = v;
    ev16.ev_neuron_id = id;
    ev16.ev_weight = w;
    ev16.ev_excitatory = x;
  endtask

  task automatic drive12(input logic v, input logic [IDW-1:0] id, input logic [WW-1:0] w, input logic x);
    ev12.ev_valid = v;
    ev12.ev_neuron_id = id;
    ev12.ev_weight = w;
    ev12.ev_excitatory = x;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (!rst_n) mdl_reset();
    else        mdl_tick();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ts16 = 1'b0;
    ts12 = 1'b0;
    drive16(0, 0, 0, 0);
    drive12(0, 0, 0, 0);
    clk_edge();
    clk_edge();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
    end
    checks++;
    if ({en16, sv16, w16, x16, busy16, done16, tsc16, drop16, lvl16} !== '0) begin
      errors++; $display("FAIL reset_zero16: got en=%h sv=%h w=%h busy=%b done=%b ts=%0d drop=%0d lvl=%0d expected all 0",
                         en16, sv16, w16, busy16, done16, tsc16, drop16, lvl16);
    end
    checks++;
    if ({en12, sv12, w12, x12, busy12, done12, tsc12, drop12, lvl12} !== '0) begin
      errors++; $display("FAIL reset_zero12: got en=%h sv=%h busy=%b done=%b lvl=%0d expected all 0",
                         en12, sv12, busy12, done12, lvl12);
    end
    checks++;
    if (ev16.ev_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ev16.ev_ready);
    end
    clk_edge();
  endtask

  task automatic test_empty_ts();
    for (int i = 0; i < 5; i++) begin
      ts16 = (i == 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL empty_ts cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (busy16 !== 1'b1) begin
          errors++; $display("FAIL empty_ts_busy: got %b expected 1", busy16);
        end
      end
      if (i == 2) begin
        checks++;
        if ({en16, sv16, busy16, done16, tsc16} !== {16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'd1}) begin
          errors++; $display("FAIL empty_ts_leak: got en=%h sv=%h busy=%b done=%b ts=%0d expected en=ffff sv=0000 busy=1 done=1 ts=1",
                             en16, sv16, busy16, done16, tsc16);
        end
      end
      if (i == 3) begin
        checks++;
        if ({busy16, done16, en16} !== {1'b0, 1'b0, 16'h0000}) begin
          errors++; $display("FAIL empty_ts_idle: got busy=%b done=%b en=%h expected 0 0 0000", busy16, done16, en16);
        end
      end
      clk_edge();
    end
    ts16 = 1'b0;
  endtask

  task automatic test_two_events();
    for (int i = 0; i < 8; i++) begin
      ts16 = 1'b0;
      drive16(0, 0, 0, 0);
      if (i == 0) drive16(1, 4'd3, 8'd20, 1'b1);
      if (i == 1) drive16(1, 4'd7, 8'd5, 1'b0);
      if (i == 2) ts16 = 1'b1;
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL two_events cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 4) begin
        checks++;
        if ({en16, sv16, w16, x16} !== {16'h0008, 16'h0008, 8'd20, 1'b1}) begin
          errors++; $display("FAIL two_events_ev1: got en=%h sv=%h w=%0d exc=%b expected 0008 0008 20 1", en16, sv16, w16, x16);
        end
      end
      if (i == 5) begin
        checks++;
        if ({en16, sv16, w16, x16} !== {16'h0080, 16'h0080, 8'd5, 1'b0}) begin
          errors++; $display("FAIL two_events_ev2: got en=%h sv=%h w=%0d exc=%b expected 0080 0080 5 0", en16, sv16, w16, x16);
        end
      end
      if (i == 6) begin
        checks++;
        if ({en16, sv16, w16, x16, done16} !== {16'hFFFF, 16'h0000, 8'd0, 1'b0, 1'b1}) begin
          errors++; $display("FAIL two_events_leak: got en=%h sv=%h w=%0d exc=%b done=%b expected ffff 0000 0 0 1",
                             en16, sv16, w16, x16, done16);
        end
      end
      clk_edge();
    end
  endtask

  task automatic test_full();
    bit held;
    for (int i = 0; i < DEPTH; i++) begin
      drive16(1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_fill cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      clk_edge();
    end
    drive16(1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    held = 1'b1;
    for (int i = 0; i < 22; i++) begin
      ts16 = (i == 0);
      if (!held) drive16(0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_drain cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if ({ev16.ev_ready, lvl16} !== {1'b0, 5'd16}) begin
          errors++; $display("FAIL full_level: got ready=%b level=%0d expected ready=0 level=16", ev16.ev_ready, lvl16);
        end
      end
      if (i == 1) begin
        checks++;
        if (ev16.ev_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready_first_pop: got %b expected 0", ev16.ev_ready);
        end
      end
      if (i == 2) begin
        checks++;
        if (ev16.ev_ready !== 1'b1) begin
          errors++; $display("FAIL full_ready_after_pop: got %b expected 1", ev16.ev_ready);
        end
      end
      if (held && ev16.ev_ready) held = 1'b0;
      clk_edge();
    end
    ts16 = 1'b0;
    drive16(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      ts16 = (i == 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_flush cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      clk_edge();
    end
    for (int i = 0; i < 16; i++) begin
      ts16 = 1'b0;
      drive16(0, 0, 0, 0);
      case (i)
        0: drive16(1, 4'd1, 8'd11, 1'b1);
        1: drive16(1, 4'd2, 8'd22, 1'b0);
        2: begin ts16 = 1'b1; drive16(1, 4'd4, 8'd44, 1'b1); end
        3: drive16(1, 4'd5, 8'd55, 1'b0);
        4: ts16 = 1'b1;
        8: ts16 = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 6) begin
        checks++;
        if ({done16, en16} !== {1'b1, 16'hFFFF}) begin
          errors++; $display("FAIL b2b_done: got done=%b en=%h expected 1 ffff", done16, en16);
        end
      end
      if (i == 7) begin
        checks++;
        if ({busy16, lvl16} !== {1'b0, 5'd2}) begin
          errors++; $display("FAIL b2b_level: got busy=%b level=%0d expected 0 2", busy16, lvl16);
        end
      end
      if (i == 10) begin
        checks++;
        if ({en16, w16, x16} !== {16'h0010, 8'd44, 1'b1}) begin
          errors++; $display("FAIL b2b_second_ev1: got en=%h w=%0d exc=%b expected 0010 44 1", en16, w16, x16);
        end
      end
      if (i == 11) begin
        checks++;
        if ({en16, w16, x16} !== {16'h0020, 8'd55, 1'b0}) begin
          errors++; $display("FAIL b2b_second_ev2: got en=%h w=%0d exc=%b expected 0020 55 0", en16, w16, x16);
        end
      end
      clk_edge();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive16(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      ts16 = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      clk_edge();
    end
    ts16 = 1'b0;
    drive16(0, 0, 0, 0);
  endtask

  task automatic test_invalid_id();
    for (int i = 0; i < 8; i++) begin
      ts12 = 1'b0;
      drive12(0, 0, 0, 0);
      if (i == 0) drive12(1, 4'd13, 8'd9, 1'b1);
      if (i == 1) drive12(1, 4'd2, 8'd33, 1'b0);
      if (i == 2) ts12 = 1'b1;
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL invalid_dut16_idle cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 2) begin
        checks++;
        if ({ev12.ev_ready, lvl12} !== {1'b1, 5'd2}) begin
          errors++; $display("FAIL invalid_level: got ready=%b level=%0d expected 1 2", ev12.ev_ready, lvl12);
        end
      end
      if (i == 3) begin
        checks++;
        if (busy12 !== 1'b1) begin
          errors++; $display("FAIL invalid_busy: got %b expected 1", busy12);
        end
      end
      if (i == 4) begin
        checks++;
        if ({en12, sv12, drop12, done12} !== {12'h000, 12'h000, 16'd1, 1'b0}) begin
          errors++; $display("FAIL invalid_drop: got en=%h sv=%h drop=%0d done=%b expected 000 000 1 0", en12, sv12, drop12, done12);
        end
      end
      if (i == 5) begin
        checks++;
        if ({en12, sv12, w12, x12, drop12} !== {12'h004, 12'h004, 8'd33, 1'b0, 16'd1}) begin
          errors++; $display("FAIL invalid_valid_ev: got en=%h sv=%h w=%0d exc=%b drop=%0d expected 004 004 33 0 1",
                             en12, sv12, w12, x12, drop12);
        end
      end
      if (i == 6) begin
        checks++;
        if ({en12, sv12, done12, tsc12} !== {12'hFFF, 12'h000, 1'b1, 16'd1}) begin
          errors++; $display("FAIL invalid_leak: got en=%h sv=%h done=%b ts=%0d expected fff 000 1 1", en12, sv12, done12, tsc12);
        end
      end
      clk_edge();
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    clk_edge();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive16(1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_fill cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      clk_edge();
    end
    drive16(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      ts16 = (i == 0);
      rst_n = (i != 3);
      @(negedge clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_mid cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
      if (i == 4) begin
        checks++;
        if ({en16, sv16, w16, x16, busy16, done16, tsc16, drop16, lvl16} !== '0) begin
          errors++; $display("FAIL reset_mid_zero: got en=%h busy=%b done=%b ts=%0d lvl=%0d expected all 0",
                             en16, busy16, done16, tsc16, lvl16);
        end
      end
      if (i > 4) begin
        checks++;
        if (done16 !== 1'b0) begin
          errors++; $display("FAIL reset_mid_no_done cyc%0d: got %b expected 0", i, done16);
        end
      end
      clk_edge();
    end
    ts16 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset();
    test_reset();
    test_empty_ts();
    test_two_events();
    test_full();
    test_back_to_back();
    test_random();
    test_invalid_id();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_timestep_scheduler.md
Name: lif_timestep_scheduler

Overview:
Buffers incoming synaptic events and sequences a bank of NUM_NEURONS parallel lif_neuron instances through one timestep per ts_start pulse. Each timestep has two phases:
- Delivery: each buffered event is delivered, one per cycle, to its target neuron by per-neuron enable and syn_valid strobes with a shared weight bus.
- Leak: one cycle that enables every neuron with syn_valid low, applying leak and advancing refractory counters.
The block sits between the AXI-side event router and the neuron array.

Parameters:
NUM_NEURONS, 16, number of neurons driven
NEURON_ID_WIDTH, 4, width of event target index
WEIGHT_WIDTH, 8, synaptic weight width; matches neuron WEIGHT_WIDTH
FIFO_DEPTH, 16, event buffer entries; power of 2
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH)
CNT_WIDTH, 16, width of timestep and drop counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ts_start  in  1  single-cycle request to process one timestep
ev_valid  in  1  event offered
ev_ready  out  1  event buffer can accept; equals FIFO not full
ev_neuron_id  in  NEURON_ID_WIDTH  target neuron index
ev_weight  in  WEIGHT_WIDTH  synaptic weight
ev_excitatory  in  1  1 excitatory, 0 inhibitory
neu_enable  out  NUM_NEURONS  per-neuron enable
neu_syn_valid  out  NUM_NEURONS  per-neuron syn_valid
neu_weight  out  WEIGHT_WIDTH  broadcast weight
neu_excitatory  out  1  broadcast polarity
busy  out  1  high while not IDLE
ts_done  out  1  one-cycle pulse at timestep completion
ts_count  out  CNT_WIDTH  completed timesteps; wraps
drop_count  out  CNT_WIDTH  discarded events; saturates at all-ones
fifo_level  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, FIFO emptied, state IDLE. Reset mid-timestep aborts the timestep with no ts_done; all buffered events are lost. Reset takes effect at the clk edge regardless of state.
- Event push: occurs when ev_valid && ev_ready. FIFO accepts pushes in every state.
  - Simultaneous push and pop: level unchanged.
  - When full: ev_ready=0 and no push; nothing is dropped at input.
- States: IDLE, DRAIN, LEAK, DONE.
- IDLE:
  - ts_start=1 at cycle T: snapshot pending = fifo_level as registered at cycle T. A push in cycle T belongs to the next timestep.
  - Go to DRAIN if pending>0, else go to LEAK.
  - ts_start while busy: ignored, with no queuing.
- DRAIN: pop one entry per cycle and decrement pending; go to LEAK when the last entry is popped.
  - Popped entry with id < NUM_NEURONS: the next cycle drives neu_enable and neu_syn_valid one-hot at id, with neu_weight and neu_excitatory taken from the entry.
  - Popped entry with id >= NUM_NEURONS: the next cycle drives all strobes 0; drop_count increments, saturating.
- LEAK: one cycle. The next cycle drives neu_enable all-ones, neu_syn_valid all-zeros, neu_weight 0, neu_excitatory 0. Then go to DONE.
- DONE: one cycle, then IDLE. During DONE, the leak strobe is on the outputs, ts_done=1, and ts_count increments.
- All neu_* outputs are registered. They are 0 in every cycle not listed above, so each neuron sees at most one enable per event plus exactly one leak enable per timestep.
- Timing with E pending events (ts_start at T):
  - Event j (1..E) appears at cycle T+1+j.
  - Leak strobe and ts_done appear at cycle T+E+2.
  - busy is high from T+1 through T+E+2.
- Events are delivered in FIFO (arrival) order. Duplicate ids are delivered as separate cycles.
- fifo_level counts from 0 to FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset then ts_start with empty FIFO at T -> busy at T+1..T+2; at T+2 neu_enable=0xFFFF, neu_syn_valid=0, ts_done=1; ts_count=1.
- Push events (3,20,exc) and (7,5,inh), then ts_start at T -> T+2: enable=syn_valid=0x0008, weight 20, exc=1. T+3: 0x0080, weight 5, exc=0. T+4: leak strobe plus ts_done.
- Push 16 events -> ev_ready=0 and fifo_level=16; a 17th ev_valid is held. ts_start drains all 16, and ev_ready returns high one cycle after the first pop.
- Push 2 events, ts_start at T, push a 3rd at T and a 4th at T+1 -> only 2 delivered, ts_done at T+4, fifo_level=2 afterwards. A second ts_start delivers the remaining 2.
- With NUM_NEURONS=12, push an event with id 13 -> that delivery cycle has all strobes 0, drop_count=1, leak still issued.
- rst_n low during DRAIN with 5 pending -> next cycle: all outputs 0, fifo_level=0, no ts_done, ts_count unchanged at 0.
